// File: rtl/sdram_arbiter_if.sv
// Requester / sequencer bundle seen by sdram_arbiter.
// Handshake: rd_req/wr_req are levels held (with a stable address) until the one-cycle
// rd_ack/wr_ack; op_start is a one-cycle pulse answered later by a one-cycle op_done.
interface sdram_arbiter_if;
    logic        init_done;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ack;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic        wr_ack;
    logic        op_start;
    logic        op_ref;
    logic        op_r_wn;
    logic [23:0] op_addr;
    logic        op_done;
    logic        busy;
    logic        ref_ovf;
    logic [2:0]  state;

    modport master (
        input  init_done, rd_req, rd_addr, wr_req, wr_addr, op_done,
        output rd_ack, wr_ack, op_start, op_ref, op_r_wn, op_addr, busy, ref_ovf, state
    );
    modport slave (
        output init_done, rd_req, rd_addr, wr_req, wr_addr, op_done,
        input  rd_ack, wr_ack, op_start, op_ref, op_r_wn, op_addr, busy, ref_ovf, state
    );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM request scheduler: periodic refresh, one read and one write requester.
// Define SDRAM_ARB_RR_EN for read/write round-robin; default is read-over-write priority.
module sdram_arbiter #(
    parameter int unsigned REF_PERIOD = 781
) (
    input  logic            clk,
    input  logic            rst_n,
    sdram_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        S_WAIT_INIT = 3'd0,
        S_IDLE      = 3'd1,
        S_REF       = 3'd2,
        S_RD        = 3'd3,
        S_WR        = 3'd4,
        S_ACK       = 3'd5
    } state_t;

    localparam logic [15:0] REF_LAST = 16'(REF_PERIOD - 1);

    state_t      state;
    logic [15:0] ref_cnt;
    logic        ref_pend;
    logic        ref_wrap;
    logic        pick_rd;
    logic        any_req;
    logic        rd_ack;
    logic        wr_ack;
    logic        op_start;
    logic        op_ref;
    logic        op_r_wn;
    logic [23:0] op_addr;
    logic        busy;
    logic        ref_ovf;

    assign ref_wrap = (state != S_WAIT_INIT) && (ref_cnt == REF_LAST);
    assign any_req  = bus.rd_req | bus.wr_req;

`ifdef SDRAM_ARB_RR_EN
    logic last_rd;  // 1 = read was served last; reset to write so read wins first contention

    assign pick_rd = bus.rd_req && !(bus.wr_req && last_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd <= 1'b0;
        end else if (state == S_IDLE && !ref_pend && any_req) begin
            last_rd <= pick_rd;
        end
    end
`else
    assign pick_rd = bus.rd_req;
`endif

    // A wrap that lands on the REF grant edge re-arms ref_pend (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
            ref_ovf  <= 1'b0;
        end else begin
            if (state == S_WAIT_INIT || ref_wrap) ref_cnt <= '0;
            else                                  ref_cnt <= ref_cnt + 16'd1;
            if (ref_wrap) begin
                ref_pend <= 1'b1;
                if (ref_pend) ref_ovf <= 1'b1;
            end else if (state == S_IDLE) begin
                ref_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_WAIT_INIT;
            rd_ack   <= 1'b0;
            wr_ack   <= 1'b0;
            op_start <= 1'b0;
            op_ref   <= 1'b0;
            op_r_wn  <= 1'b1;
            op_addr  <= '0;
            busy     <= 1'b1;
        end else begin
            op_start <= 1'b0;
            rd_ack   <= 1'b0;
            wr_ack   <= 1'b0;
            case (state)
                S_WAIT_INIT: begin
                    if (bus.init_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (ref_pend) begin
                        state    <= S_REF;
                        op_start <= 1'b1;
                        op_ref   <= 1'b1;
                        busy     <= 1'b1;
                    end else if (any_req) begin
                        state    <= pick_rd ? S_RD : S_WR;
                        op_start <= 1'b1;
                        op_r_wn  <= pick_rd;
                        op_addr  <= pick_rd ? bus.rd_addr : bus.wr_addr;
                        busy     <= 1'b1;
                    end
                end
                S_REF: begin
                    if (bus.op_done) begin
                        state  <= S_IDLE;
                        op_ref <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                S_RD, S_WR: begin
                    if (bus.op_done) begin
                        state  <= S_ACK;
                        rd_ack <= op_r_wn;
                        wr_ack <= !op_r_wn;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_WAIT_INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rd_ack   = rd_ack;
    assign bus.wr_ack   = wr_ack;
    assign bus.op_start = op_start;
    assign bus.op_ref   = op_ref;
    assign bus.op_r_wn  = op_r_wn;
    assign bus.op_addr  = op_addr;
    assign bus.busy     = busy;
    assign bus.ref_ovf  = ref_ovf;
    assign bus.state    = state;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: random requesters and sequencer, event scoreboard fed by a
// cycle-level reference model built from refresh-interval arithmetic and grant rules.
module tb_sdram_arbiter;
    localparam int REF_P = 32;
`ifdef SDRAM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif
    localparam logic [2:0] EV_REF = 3'd1, EV_RD = 3'd2, EV_WR = 3'd3, EV_RACK = 3'd4, EV_WACK = 3'd5;
    localparam int OP_NONE = 0, OP_REF = 1, OP_DATA = 2;

    logic clk;
    logic rst_n;
    sdram_arbiter_if bus();

    sdram_arbiter #(.REF_PERIOD(REF_P)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ref_seen = 0;
    int ack_seen = 0;
    logic [47:0] exp_q[$];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, exp);
        end
    endtask

    // reference model state
    bit          m_run, m_pend, m_ovf, m_ack, m_rwn, m_last_rd;
    int          m_op;
    int          m_edges;
    logic [23:0] m_addr;

    task automatic push_ev(input logic [2:0] kind);
        exp_q.push_back({cyc[19:0], kind, m_rwn, m_addr});
    endtask

    always @(posedge clk) begin
        bit wrap, took_ref, serve_rd;
        cyc++;
        took_ref = 1'b0;
        if (!rst_n) begin
            m_run = 0; m_pend = 0; m_ovf = 0; m_ack = 0; m_rwn = 1; m_last_rd = 0;
            m_op = OP_NONE; m_edges = 0; m_addr = '0;
        end else if (!m_run) begin
            if (bus.init_done) begin
                m_run = 1;
                m_edges = 0;
            end
        end else begin
            // refresh interval elapses on every REF_P-th edge after leaving init
            wrap = (m_edges % REF_P) == REF_P - 1;
            m_edges++;
            if (m_ack) begin
                m_ack = 0;
            end else if (m_op == OP_NONE) begin
                if (m_pend) begin
                    m_op = OP_REF;
                    took_ref = 1'b1;
                    push_ev(EV_REF);
                end else if (bus.rd_req || bus.wr_req) begin
                    serve_rd = bus.rd_req && !(RR_MODE && bus.wr_req && m_last_rd);
                    m_last_rd = serve_rd;
                    m_rwn = serve_rd;
                    m_addr = serve_rd ? bus.rd_addr : bus.wr_addr;
                    m_op = OP_DATA;
                    push_ev(serve_rd ? EV_RD : EV_WR);
                end
            end else if (bus.op_done) begin
                if (m_op == OP_DATA) begin
                    m_ack = 1;
                    push_ev(m_rwn ? EV_RACK : EV_WACK);
                end
                m_op = OP_NONE;
            end
            if (wrap) begin
                if (m_pend) m_ovf = 1;
                m_pend = 1;
            end else if (took_ref) begin
                m_pend = 0;
            end
        end
    end

    // scoreboard monitor
    task automatic match_ev(input logic [2:0] kind);
        logic [47:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event at cycle %0d: got kind %0d required none", cyc, kind);
        end else begin
            exp = exp_q.pop_front();
            if ({cyc[19:0], kind, bus.op_r_wn, bus.op_addr} !== exp) begin
                n_fail++;
                $display("FAIL event at cycle %0d: got %h required %h", cyc,
                         {cyc[19:0], kind, bus.op_r_wn, bus.op_addr}, exp);
            end
        end
    endtask

    always @(posedge clk) begin
        logic [47:0] miss;
        #1;
        if (bus.op_start) begin
            match_ev(bus.op_ref ? EV_REF : (bus.op_r_wn ? EV_RD : EV_WR));
            if (bus.op_ref) ref_seen++;
        end
        if (bus.rd_ack) begin match_ev(EV_RACK); ack_seen++; end
        if (bus.wr_ack) begin match_ev(EV_WACK); ack_seen++; end
        while (exp_q.size() > 0 && exp_q[0][47:28] <= cyc[19:0]) begin
            miss = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missed_event at cycle %0d: got nothing required %h", cyc, miss);
        end
        chk("busy",    48'(bus.busy),    48'(!m_run || m_op != OP_NONE || m_ack));
        chk("op_ref",  48'(bus.op_ref),  48'(m_op == OP_REF));
        chk("ref_ovf", 48'(bus.ref_ovf), 48'(m_ovf));
        chk("op_r_wn", 48'(bus.op_r_wn), 48'(m_rwn));
        chk("op_addr", 48'(bus.op_addr), 48'(m_addr));
    end

    // sequencer model
    int fixed_delay = 5;
    bit stall_ref   = 0;
    bit data_stall  = 0;
    bit spur_en     = 0;
    int seq_cnt     = 0;
    bit seq_active  = 0;

    always @(negedge clk) begin
        int d;
        if (!rst_n) begin
            seq_cnt = 0;
            seq_active = 0;
            bus.op_done = 1'b0;
        end else begin
            bus.op_done = 1'b0;
            if (seq_cnt > 0) begin
                seq_cnt--;
                if (seq_cnt == 0) begin
                    bus.op_done = 1'b1;
                    seq_active = 0;
                end
            end
            if (bus.op_start) begin
                if (bus.op_ref && stall_ref) begin
                    d = 2 * REF_P + 3;
                    stall_ref = 0;
                end else if (!bus.op_ref && data_stall) d = 400;
                else if (fixed_delay >= 0)              d = fixed_delay;
                else                                    d = $urandom_range(0, 6);
                if (d == 0) bus.op_done = 1'b1;
                else begin
                    seq_cnt = d;
                    seq_active = 1;
                end
            end else if (spur_en && !seq_active && $urandom_range(0, 7) == 0) begin
                bus.op_done = 1'b1;
            end
        end
    end

    // requester driver: raise request, hold until ack, drop during the ack cycle
    task automatic do_req(input bit is_rd, input logic [23:0] addr);
        bit got;
        got = 0;
        @(negedge clk);
        if (is_rd) begin bus.rd_req = 1'b1; bus.rd_addr = addr; end
        else       begin bus.wr_req = 1'b1; bus.wr_addr = addr; end
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (is_rd ? bus.rd_ack : bus.wr_ack) got = 1;
        end
        chk(is_rd ? "rd_ack_timeout" : "wr_ack_timeout", 48'(got), 48'd1);
        if (is_rd) bus.rd_req = 1'b0;
        else       bus.wr_req = 1'b0;
    endtask

    task automatic rand_traffic(input bit is_rd, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            do_req(is_rd, 24'($urandom));
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b1;
        bus.init_done = 1'b0;
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        bus.rd_addr = '0;  bus.wr_addr = '0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy",    48'(bus.busy),     48'd1);
        chk("rst_op_r_wn", 48'(bus.op_r_wn),  48'd1);
        chk("rst_op_addr", 48'(bus.op_addr),  48'd0);
        chk("rst_op_start",48'(bus.op_start), 48'd0);
        chk("rst_ref_ovf", 48'(bus.ref_ovf),  48'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        bus.init_done = 1'b1;

        // idle: one refresh after the first interval, no acks
        repeat (60) @(negedge clk);
        chk("p1_ref_count", 48'(ref_seen), 48'd1);
        chk("p1_no_ack",    48'(ack_seen), 48'd0);

        // directed write
        fixed_delay = 3;
        do_req(1'b0, 24'hA51234);
        chk("wr_op_addr", 48'(bus.op_addr), 48'hA51234);
        chk("wr_op_r_wn", 48'(bus.op_r_wn), 48'd0);

        // simultaneous back-to-back read and write streams
        fixed_delay = -1;
        fork
            for (int i = 0; i < 4; i++) do_req(1'b1, 24'h100000 + 24'(i));
            for (int i = 0; i < 4; i++) do_req(1'b0, 24'h200000 + 24'(i));
        join

        // random traffic with spurious op_done
        spur_en = 1;
        fork
            rand_traffic(1'b1, 25);
            rand_traffic(1'b0, 25);
        join
        spur_en = 0;

        // refresh stalled over two intervals
        stall_ref = 1;
        repeat (4 * REF_P + 20) @(negedge clk);
        chk("ovf_sticky", 48'(bus.ref_ovf), 48'd1);

        // reset in the middle of a write
        data_stall = 1;
        fork
            do_req(1'b0, 24'h3C5A5A);
            begin
                found = 0;
                for (int i = 0; i < 300 && !found; i++) begin
                    @(negedge clk);
                    if (bus.op_start && !bus.op_ref && !bus.op_r_wn) found = 1;
                end
                chk("wr_started", 48'(found), 48'd1);
                repeat (2) @(negedge clk);
                rst_n = 1'b0;
                bus.init_done = 1'b0;
                data_stall = 0;
                #1;
                chk("async_busy",    48'(bus.busy),    48'd1);
                chk("async_op_r_wn", 48'(bus.op_r_wn), 48'd1);
                chk("async_op_addr", 48'(bus.op_addr), 48'd0);
                chk("async_ref_ovf", 48'(bus.ref_ovf), 48'd0);
                chk("async_wr_ack",  48'(bus.wr_ack),  48'd0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (4) @(negedge clk);
                bus.init_done = 1'b1;
            end
        join
        chk("post_rst_addr", 48'(bus.op_addr), 48'h3C5A5A);

        repeat (20) @(negedge clk);
        chk("exp_q_empty", 48'(exp_q.size()), 48'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
